// File: rtl/oam_dma_pkg.sv
// Shared constants and FSM state encoding for the oam_dma sprite DMA engine.
package oam_dma_pkg;

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_PORT = 16'h2004;
    localparam int          LEN      = 256;
    localparam logic [7:0]  CNT_LAST = 8'(LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_e;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine and CPU bus master mux: a CPU write to DMA_REG halts the CPU and copies one
// 256-byte page to OAM_PORT. Define OAM_DMA_ALIGN_EN to add the odd-cycle ALIGN wait state.
module oam_dma
    import oam_dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [15:0] cpu_memaddr,
    input  logic [7:0]  cpu_memwdata,
    input  logic        cpu_memwr,
    input  logic        cpu_memreq,
    output logic        cpu_memack,
    output logic [7:0]  cpu_memrdata,
    output logic        halt,
    output logic [15:0] memaddr,
    output logic [7:0]  memwdata,
    output logic        memwr,
    output logic        memreq,
    input  logic        memack,
    input  logic [7:0]  memrdata,
    output logic [2:0]  dbg_state,
    output logic        dbg_odd,
    output logic        dbg_err
);

    state_e     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       odd_q, odd_d;
    logic       tick0_q, tick0_d;
    logic       req_q, req_d;
    logic       err_q, err_d;
    logic       trigger, dma_bus, acked;

    assign trigger = tick && cpu_memwr && (cpu_memaddr == DMA_REG);
    assign dma_bus = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign acked   = req_q && memack;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        odd_d   = odd_q ^ tick;
        tick0_d = tick;
        req_d   = req_q;
        err_d   = err_q | (tick & req_q & ~memack & dma_bus);
        // A DMA request opens on the clk after a tick and is held until the bus acks it.
        if (tick0_q && dma_bus) req_d = 1'b1;
        if (acked)              req_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    page_d  = cpu_memwdata;
                    cnt_d   = 8'd0;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (tick) begin
`ifdef OAM_DMA_ALIGN_EN
                    state_d = odd_q ? ST_ALIGN : ST_READ;
`else
                    state_d = ST_READ;
`endif
                end
            end
            ST_ALIGN: begin
                if (tick) state_d = ST_READ;
            end
            ST_READ: begin
                if (acked) data_d = memrdata;
                if (tick)  state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (tick) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q != CNT_LAST) begin
                        state_d = ST_READ;
                    end else if (trigger) begin
                        // Back-to-back trigger on the final tick starts a fresh transfer.
                        page_d  = cpu_memwdata;
                        cnt_d   = 8'd0;
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            page_q  <= 8'd0;
            cnt_q   <= 8'd0;
            data_q  <= 8'd0;
            odd_q   <= 1'b0;
            tick0_q <= 1'b0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            odd_q   <= odd_d;
            tick0_q <= tick0_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    // The CPU owns the bus only in IDLE; otherwise it is halted and sees no acks.
    always_comb begin
        cpu_memrdata = memrdata;
        if (state_q == ST_IDLE) begin
            memaddr    = cpu_memaddr;
            memwdata   = cpu_memwdata;
            memwr      = cpu_memwr;
            memreq     = cpu_memreq;
            cpu_memack = memack;
        end else begin
            memaddr    = (state_q == ST_WRITE) ? OAM_PORT : {page_q, cnt_q};
            memwdata   = data_q;
            memwr      = (state_q == ST_WRITE);
            memreq     = req_q;
            cpu_memack = 1'b0;
        end
    end

    assign halt      = (state_q != ST_IDLE);
    assign dbg_state = state_q;
    assign dbg_odd   = odd_q;
    assign dbg_err   = err_q;

endmodule
